// File: rtl/line_mem_responder.sv
// Single-ported, multi-cycle line memory answering cache-controller line reads/writes
// with a one-cycle mem_rdy completion pulse after a fixed LATENCY.
module line_mem_responder #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rdy,
    output logic              mem_busy
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_we_q;

    logic                accept;
    logic                commit;
    logic                rdy_d;
    logic                busy_d;

    logic [DATA_W-1:0]   mem_array [DEPTH];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_we || mem_re) state_d = BUSY;
            BUSY: if (cnt_q == '0)      state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Control decode; rdy/busy are computed one cycle early and registered
    always_comb begin
        accept = 1'b0;
        commit = 1'b0;
        rdy_d  = 1'b0;
        busy_d = 1'b0;
        accept = (state_q == IDLE) && (mem_we || mem_re);
        commit = (state_q == BUSY) && (cnt_q == '0);
        rdy_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // Request latch, latency counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_we_q     <= 1'b0;
            mem_rd_data <= '0;
            mem_rdy     <= 1'b0;
            mem_busy    <= 1'b0;
        end else begin
            mem_rdy  <= rdy_d;
            mem_busy <= busy_d;
            if (accept) begin
                cnt_q   <= CNT_W'(LATENCY - 2);
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                op_we_q <= mem_we;
            end else if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit && !op_we_q) begin
                mem_rd_data <= mem_array[addr_q];
            end
        end
    end

    // Storage array is intentionally left uninitialised by reset
    always_ff @(posedge clk) begin
        if (commit && op_we_q) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder: latency, data path,
// write priority, back-to-back spacing, reset abort and input isolation while busy.
module tb_line_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rd_data;
    logic        mem_rdy;
    logic        mem_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int rdy_cnt  = 0;

    line_mem_responder #(.ADDR_W(14), .DATA_W(64), .LATENCY(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rd_data(mem_rd_data),
        .mem_rdy    (mem_rdy),
        .mem_busy   (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_rdy === 1'b1) rdy_cnt <= rdy_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request (caller is #1 after a rising edge), hold it until rdy,
    // drop it after the edge that ends the rdy cycle.
    task automatic xact(input string tag, input logic we, input logic re,
                        input logic [13:0] addr, input logic [63:0] wdata,
                        input bit mutate, output int rdy_cyc, output logic [63:0] rd);
        int  lat;
        bit  busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        rdy_cyc = -1;
        rd      = '0;
        mem_we    = we;
        mem_re    = re;
        mem_addr  = addr;
        mem_wdata = wdata;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mutate && k == 0) begin
                mem_addr  = ~addr;
                mem_wdata = ~wdata;
            end
            if (mem_busy !== 1'b1) busy_ok = 1'b0;
            if (mem_rdy === 1'b1) begin
                lat     = k + 1;
                rdy_cyc = cyc;
                rd      = mem_rd_data;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        @(posedge clk); #1;
        check({tag, "_rdy_pulse"}, 64'(mem_rdy), 64'd0);
        check({tag, "_idle_busy"}, 64'(mem_busy), 64'd0);
        mem_we = 1'b0;
        mem_re = 1'b0;
    endtask

    int          r1, r2, rc0;
    logic [63:0] rd;

    initial begin
        rst_n     = 1'b1;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdy", 64'(mem_rdy), 64'd0);
        check("rst_busy", 64'(mem_busy), 64'd0);
        check("rst_data", mem_rd_data, 64'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back
        xact("wr5", 1'b1, 1'b0, 14'h0005, 64'h0123_4567_89AB_CDEF, 1'b0, r1, rd);
        xact("rd5", 1'b0, 1'b1, 14'h0005, 64'h0, 1'b0, r1, rd);
        check("rd5_data", rd, 64'h0123_4567_89AB_CDEF);

        // re and we together: write wins, read data untouched
        xact("both", 1'b1, 1'b1, 14'h3FFF, 64'hDEAD_BEEF_0000_0001, 1'b0, r1, rd);
        check("both_rd_held", mem_rd_data, 64'h0123_4567_89AB_CDEF);
        xact("rd3fff", 1'b0, 1'b1, 14'h3FFF, 64'h0, 1'b0, r1, rd);
        check("rd3fff_data", rd, 64'hDEAD_BEEF_0000_0001);

        // Back-to-back reads of 0x0000 / 0x3FFF
        xact("wr0", 1'b1, 1'b0, 14'h0000, 64'hA5A5_0000_1111_2222, 1'b0, r1, rd);
        rc0 = rdy_cnt;
        xact("b2b_a", 1'b0, 1'b1, 14'h0000, 64'h0, 1'b0, r1, rd);
        check("b2b_a_data", rd, 64'hA5A5_0000_1111_2222);
        xact("b2b_b", 1'b0, 1'b1, 14'h3FFF, 64'h0, 1'b0, r2, rd);
        check("b2b_b_data", rd, 64'hDEAD_BEEF_0000_0001);
        check("b2b_spacing", 64'(r2 - r1), 64'd5);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_pulses", 64'(rdy_cnt - rc0), 64'd2);

        // Reset in the middle of a write aborts it
        xact("wr10", 1'b1, 1'b0, 14'h0010, 64'h1111_2222_3333_4444, 1'b0, r1, rd);
        rc0 = rdy_cnt;
        mem_we    = 1'b1;
        mem_addr  = 14'h0010;
        mem_wdata = 64'h9999_8888_7777_6666;
        @(posedge clk); #1;
        check("abort_busy_t1", 64'(mem_busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rdy", 64'(mem_rdy), 64'd0);
        check("midrst_busy", 64'(mem_busy), 64'd0);
        check("midrst_data", mem_rd_data, 64'h0);
        mem_we = 1'b0;
        #2 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_rdy", 64'(rdy_cnt - rc0), 64'd0);
        xact("rd10", 1'b0, 1'b1, 14'h0010, 64'h0, 1'b0, r1, rd);
        check("rd10_uncommitted", rd, 64'h1111_2222_3333_4444);

        // Inputs changed while busy are ignored
        xact("wr_inv", 1'b1, 1'b0, ~14'h0020, 64'h5555_5555_5555_5555, 1'b0, r1, rd);
        xact("wr_mut", 1'b1, 1'b0, 14'h0020, 64'hCAFE_F00D_1234_5678, 1'b1, r1, rd);
        xact("rd20", 1'b0, 1'b1, 14'h0020, 64'h0, 1'b0, r1, rd);
        check("rd20_data", rd, 64'hCAFE_F00D_1234_5678);
        xact("rd_inv", 1'b0, 1'b1, ~14'h0020, 64'h0, 1'b0, r1, rd);
        check("rd_inv_data", rd, 64'h5555_5555_5555_5555);
        repeat (2) @(posedge clk);
        #1;
        check("rd_data_held", mem_rd_data, 64'h5555_5555_5555_5555);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
